cache_ram_arbiter: RTL and testbench
====================================

# cache_ram_arbiter

Two-port round-robin arbiter that shares one external RAM word interface between two cache controllers, e.g. an instruction cache and a data cache. It sits between the caches' `ram_*` ports and the single RAM. Once it grants a port, the grant is held for a complete line transaction: an optional dirty write-back burst followed by the fill burst. The other cache never sees a split or interleaved line.

## Interface
- `ADDRESS_WIDTH`, default 16: byte address width, matching the caches.
- `WORD_OFFSET_WIDTH`, default 2: log2 of words per line. Burst length is N = 2**WORD_OFFSET_WIDTH beats. Must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `c0_ram_address`, `c1_ram_address`  in  ADDRESS_WIDTH  cache-side address, port 0 / port 1.
- `c0_ram_rd`, `c1_ram_rd`  in  1  cache read request (level).
- `c0_ram_wr`, `c1_ram_wr`  in  1  cache write request (level).
- `c0_ram_data_wr`, `c1_ram_data_wr`  in  32  cache write data.
- `c0_ram_data_rd`, `c1_ram_data_rd`  out  32  read data; both are a direct copy of `ram_data_rd`.
- `c0_ram_data_valid`, `c1_ram_data_valid`  out  1  `ram_data_valid` gated by grant.
- `ram_address`  out  ADDRESS_WIDTH  to RAM.
- `ram_rd`, `ram_wr`  out  1  to RAM.
- `ram_data_wr`  out  32  to RAM.
- `ram_data_rd`  in  32  from RAM.
- `ram_data_valid`  in  1  RAM beat-complete strobe.
- `grant`  out  2  one-hot grant: bit0 = port 0, bit1 = port 1, 00 = idle.

## Operation
- **State machine.** States are IDLE, GRANT0 and GRANT1. Registers are:
  - `beat_cnt` (WORD_OFFSET_WIDTH bits), wraps N-1 → 0;
  - `last` (1 bit), the most recently granted port.
- **Port request.** Request for port i is `ci_ram_rd | ci_ram_wr`.
- **IDLE.**
  - One requester: go to its GRANT state.
  - Both requesting: grant the port ≠ `last`.
  - On any grant: `last` ← granted port, `beat_cnt` ← 0.
- **GRANTi datapath.**
  - `ram_address`, `ram_rd`, `ram_wr` and `ram_data_wr` are combinational copies of port i's inputs.
  - `ci_ram_data_valid` = `ram_data_valid`.
  - The other port's valid = 0.
- **IDLE datapath.** `ram_rd` = `ram_wr` = 0, `ram_address` = 0, `ram_data_wr` = 0, both valids 0.
- **Beat counting.** A beat is a cycle in GRANTi with `ram_data_valid` = 1. Its type is write if `ci_ram_wr` = 1 that cycle, else read.
  - Beat with `beat_cnt` < N-1: increment `beat_cnt`.
  - Write beat with `beat_cnt` = N-1: `beat_cnt` ← 0 and the grant is kept, because the fill burst follows the write-back.
  - Read beat with `beat_cnt` = N-1: the grant is released.
- **Release.**
  - If the other port is requesting that cycle, go directly to its GRANT state. `last` and `beat_cnt` update as for an IDLE grant.
  - Otherwise go to IDLE.
  - The releasing port is never re-granted on the release edge, even if its request is still high. Caches drop `ram_rd` one cycle after the last beat.
- **Starvation bound.** Round-robin guarantees a waiting port is granted at the end of the current line transaction.
- **Grant scope.** `grant` reflects the state register only.

## Timing
- **Reset.** On `rst` at a rising edge:
  - state ← IDLE, `beat_cnt` ← 0, `last` ← 1 (so port 0 wins the first simultaneous request);
  - all outputs return to their IDLE values (all 0) from that edge.
  - Reset mid-burst abandons the burst with no further valids.
- **Grant latency.** A request first seen high at edge t in IDLE is granted at t (GRANT from t+1). RAM sees the request from t+1.
- **Datapath latency.** Zero added latency inside a grant. `ram_data_valid` → `ci_ram_data_valid` is combinational.
- **Handover.** Last read beat at cycle t:
  - waiting port granted and on RAM in cycle t+1;
  - with no waiter, IDLE in t+1 and the earliest re-grant is in t+2.
- **Simultaneous requests in IDLE.** Decided by `last` only.
- **No-request grant.** A granted port with both rd and wr low holds the grant; no timeout.
- **Valid outside a burst.** `ram_data_valid` in IDLE is ignored and changes no state.

## Test plan
- **Reset.** Hold `rst` 2 cycles with both ports requesting. Required: `grant` = 00 and `ram_rd`/`ram_wr` = 0 through reset. GRANT0 at the first edge after reset, since port 0 wins with `last` = 1.
- **Single fill.** With N = 4, port 1 reads at addr 0x0040 and the RAM returns 4 valids one cycle apart. Required:
  - `c1_ram_data_valid` pulses 4×, `c0_ram_data_valid` stays 0;
  - `grant` = 10 for exactly the burst cycles, then 00.
- **Write-back then fill.** Port 0 drives 4 write beats then 4 read beats. Required: `grant` stays 01 across all 8 beats with no idle gap, and releases after the 8th beat.
- **Contention handover.** Port 1 requests while port 0 is mid-fill. Required:
  - port 1 sees no valid until port 0's 4th read beat;
  - `grant` goes 01 → 10 on the next cycle;
  - `ram_address` switches to `c1_ram_address` that cycle.
- **Fairness.** Both ports request continuously over 4 line fills. Required: grant order 0, 1, 0, 1.
- **Reset mid-burst.** Assert `rst` after 2 of 4 beats. Required: `grant` = 00 next cycle, a later valid is ignored, and a fresh request restarts `beat_cnt` at 0.

Source files
------------

// File: rtl/cache_ram_arbiter.sv
// rtl/cache_ram_arbiter.sv - two-port round-robin arbiter sharing one RAM word interface between two caches
//
// Purpose: grants one cache at a time for a whole line transaction (an optional
// write-back burst followed by a fill burst). Alternates ports on contention.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   c0_ram_* / c1_ram_*         cache-side address, rd/wr requests, write data,
//                               read data (copy of ram_data_rd), gated data valid
//   ram_address, ram_rd, ram_wr, ram_data_wr   muxed request to the RAM
//   ram_data_rd, ram_data_valid                RAM read data and beat strobe
//   grant                       one-hot grant (bit0 = port 0, bit1 = port 1)
module cache_ram_arbiter #(
  parameter int ADDRESS_WIDTH     = 16,
  parameter int WORD_OFFSET_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] c0_ram_address,
  input  logic                     c0_ram_rd,
  input  logic                     c0_ram_wr,
  input  logic [31:0]              c0_ram_data_wr,
  output logic [31:0]              c0_ram_data_rd,
  output logic                     c0_ram_data_valid,
  input  logic [ADDRESS_WIDTH-1:0] c1_ram_address,
  input  logic                     c1_ram_rd,
  input  logic                     c1_ram_wr,
  input  logic [31:0]              c1_ram_data_wr,
  output logic [31:0]              c1_ram_data_rd,
  output logic                     c1_ram_data_valid,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_rd,
  output logic                     ram_wr,
  output logic [31:0]              ram_data_wr,
  input  logic [31:0]              ram_data_rd,
  input  logic                     ram_data_valid,
  output logic [1:0]               grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [WORD_OFFSET_WIDTH-1:0] BEAT_LAST = '1;

  state_t                       state, state_next;
  logic [WORD_OFFSET_WIDTH-1:0] beat_cnt, beat_next;
  logic                         last, last_next;
  logic                         req0, req1;

  assign req0 = c0_ram_rd | c0_ram_wr;
  assign req1 = c1_ram_rd | c1_ram_wr;

  assign c0_ram_data_rd = ram_data_rd;
  assign c1_ram_data_rd = ram_data_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last     <= 1'b1;  // port 0 wins the first simultaneous request
    end else begin
      state    <= state_next;
      beat_cnt <= beat_next;
      last     <= last_next;
    end
  end

  always_comb begin
    state_next        = state;
    beat_next         = beat_cnt;
    last_next         = last;
    ram_address       = '0;
    ram_rd            = 1'b0;
    ram_wr            = 1'b0;
    ram_data_wr       = '0;
    c0_ram_data_valid = 1'b0;
    c1_ram_data_valid = 1'b0;
    grant             = 2'b00;

    case (state)
      IDLE: begin
        // Port 0 wins when alone, or when both request and port 1 was served last.
        if (req0 && (!req1 || last)) begin
          state_next = GRANT0;
          last_next  = 1'b0;
          beat_next  = '0;
        end else if (req1) begin
          state_next = GRANT1;
          last_next  = 1'b1;
          beat_next  = '0;
        end
      end

      GRANT0: begin
        grant             = 2'b01;
        ram_address       = c0_ram_address;
        ram_rd            = c0_ram_rd;
        ram_wr            = c0_ram_wr;
        ram_data_wr       = c0_ram_data_wr;
        c0_ram_data_valid = ram_data_valid;
        if (ram_data_valid) begin
          if (beat_cnt != BEAT_LAST) begin
            beat_next = beat_cnt + 1'b1;
          end else if (c0_ram_wr) begin
            beat_next = '0;  // write-back done, fill burst follows under same grant
          end else if (req1) begin
            state_next = GRANT1;
            last_next  = 1'b1;
            beat_next  = '0;
          end else begin
            state_next = IDLE;
            beat_next  = '0;
          end
        end
      end

      GRANT1: begin
        grant             = 2'b10;
        ram_address       = c1_ram_address;
        ram_rd            = c1_ram_rd;
        ram_wr            = c1_ram_wr;
        ram_data_wr       = c1_ram_data_wr;
        c1_ram_data_valid = ram_data_valid;
        if (ram_data_valid) begin
          if (beat_cnt != BEAT_LAST) begin
            beat_next = beat_cnt + 1'b1;
          end else if (c1_ram_wr) begin
            beat_next = '0;
          end else if (req0) begin
            state_next = GRANT0;
            last_next  = 1'b0;
            beat_next  = '0;
          end else begin
            state_next = IDLE;
            beat_next  = '0;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// tb/tb_cache_ram_arbiter.sv - self-checking bench for cache_ram_arbiter
module tb_cache_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] c0_ram_address, c1_ram_address;
  logic        c0_ram_rd, c0_ram_wr, c1_ram_rd, c1_ram_wr;
  logic [31:0] c0_ram_data_wr, c1_ram_data_wr;
  logic [31:0] c0_ram_data_rd, c1_ram_data_rd;
  logic        c0_ram_data_valid, c1_ram_data_valid;
  logic [15:0] ram_address;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_data_wr, ram_data_rd;
  logic        ram_data_valid;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  cache_ram_arbiter #(.ADDRESS_WIDTH(16), .WORD_OFFSET_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .c0_ram_address(c0_ram_address), .c0_ram_rd(c0_ram_rd), .c0_ram_wr(c0_ram_wr),
    .c0_ram_data_wr(c0_ram_data_wr), .c0_ram_data_rd(c0_ram_data_rd),
    .c0_ram_data_valid(c0_ram_data_valid),
    .c1_ram_address(c1_ram_address), .c1_ram_rd(c1_ram_rd), .c1_ram_wr(c1_ram_wr),
    .c1_ram_data_wr(c1_ram_data_wr), .c1_ram_data_rd(c1_ram_data_rd),
    .c1_ram_data_valid(c1_ram_data_valid),
    .ram_address(ram_address), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_data_wr(ram_data_wr), .ram_data_rd(ram_data_rd),
    .ram_data_valid(ram_data_valid), .grant(grant)
  );

  // One record per clock cycle: inputs held for the cycle, grant expected in it.
  typedef struct {
    string      name;
    logic       rst, r0, w0, r1, w1, v;
    logic [1:0] g;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input string name, input logic rs, input logic r0,
                              input logic w0, input logic r1, input logic w1,
                              input logic v, input logic [1:0] g);
    vec_t t;
    t.name = name; t.rst = rs; t.r0 = r0; t.w0 = w0;
    t.r1 = r1; t.w1 = w1; t.v = v; t.g = g;
    return t;
  endfunction

  task automatic step(input vec_t t);
    logic [15:0] e_addr;
    logic        e_rd, e_wr, e_v0, e_v1;
    logic [31:0] e_dwr, rdata;
    @(negedge clk);
    rdata          = $urandom;
    rst            = t.rst;
    c0_ram_rd      = t.r0;
    c0_ram_wr      = t.w0;
    c1_ram_rd      = t.r1;
    c1_ram_wr      = t.w1;
    ram_data_valid = t.v;
    ram_data_rd    = rdata;
    #1;
    // Datapath follows the granted port; idle drives zeros.
    e_addr = 16'h0; e_rd = 1'b0; e_wr = 1'b0; e_dwr = 32'h0;
    if (t.g == 2'b01) begin
      e_addr = 16'h0100; e_rd = t.r0; e_wr = t.w0; e_dwr = 32'hC0C0_1234;
    end else if (t.g == 2'b10) begin
      e_addr = 16'h0040; e_rd = t.r1; e_wr = t.w1; e_dwr = 32'hC1C1_5678;
    end
    e_v0 = t.g[0] & t.v;
    e_v1 = t.g[1] & t.v;
    vectors++;
    if (grant !== t.g || ram_address !== e_addr || ram_rd !== e_rd || ram_wr !== e_wr ||
        ram_data_wr !== e_dwr || c0_ram_data_valid !== e_v0 || c1_ram_data_valid !== e_v1 ||
        c0_ram_data_rd !== rdata || c1_ram_data_rd !== rdata) begin
      miscompares++;
      $display("FAIL %s vec%0d: got grant=%b addr=%h rd=%b wr=%b dwr=%h v0=%b v1=%b drd0=%h drd1=%h; expected grant=%b addr=%h rd=%b wr=%b dwr=%h v0=%b v1=%b drd=%h",
               t.name, vectors, grant, ram_address, ram_rd, ram_wr, ram_data_wr,
               c0_ram_data_valid, c1_ram_data_valid, c0_ram_data_rd, c1_ram_data_rd,
               t.g, e_addr, e_rd, e_wr, e_dwr, e_v0, e_v1, rdata);
    end
  endtask

  initial begin
    rst = 1'b1; c0_ram_rd = 0; c0_ram_wr = 0; c1_ram_rd = 0; c1_ram_wr = 0;
    ram_data_valid = 0; ram_data_rd = '0;
    c0_ram_address = 16'h0100; c1_ram_address = 16'h0040;
    c0_ram_data_wr = 32'hC0C0_1234; c1_ram_data_wr = 32'hC1C1_5678;

    // Reset with both requesting, then port 0 fill while port 1 waits (handover).
    tbl.push_back(mk("reset",   1, 1,0, 1,0, 0, 2'b00));
    tbl.push_back(mk("reset",   1, 1,0, 1,0, 1, 2'b00));
    tbl.push_back(mk("first",   0, 1,0, 1,0, 0, 2'b00));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("p0_fill", 0, 1,0, 1,0, 1, 2'b01));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("handover", 0, 0,0, 1,0, 1, 2'b10));
    tbl.push_back(mk("release", 0, 0,0, 0,0, 0, 2'b00));
    // Valid while idle is ignored.
    tbl.push_back(mk("idle_v",  0, 0,0, 0,0, 1, 2'b00));
    // Single fill for port 1 with gaps between valids.
    tbl.push_back(mk("p1_req",  0, 0,0, 1,0, 0, 2'b00));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk("p1_gap",  0, 0,0, 1,0, 0, 2'b10));
      tbl.push_back(mk("p1_beat", 0, 0,0, 1,0, 1, 2'b10));
    end
    // Port 1 still requesting on the release edge: idle first, re-grant one cycle later.
    tbl.push_back(mk("no_regrant", 0, 0,0, 1,0, 0, 2'b00));
    tbl.push_back(mk("regrant",    0, 0,0, 0,0, 0, 2'b10));
    tbl.push_back(mk("hold",       0, 0,0, 0,0, 0, 2'b10));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("hold_beat", 0, 0,0, 0,0, 1, 2'b10));
    tbl.push_back(mk("hold_rel",   0, 0,0, 0,0, 0, 2'b00));

    foreach (tbl[i]) step(tbl[i]);

    // Write-back then fill on port 0: grant held across all 8 beats.
    step(mk("wb_req", 0, 0,1, 0,0, 0, 2'b00));
    for (int i = 0; i < 4; i++) step(mk("wb_write", 0, 0,1, 0,0, 1, 2'b01));
    for (int i = 0; i < 4; i++) step(mk("wb_fill",  0, 1,0, 0,0, 1, 2'b01));
    step(mk("wb_release", 0, 0,0, 0,0, 0, 2'b00));

    // Fairness: reset so last = 1, then both request over 4 fills: 0,1,0,1.
    step(mk("fair_rst", 1, 0,0, 0,0, 0, 2'b00));
    step(mk("fair_req", 0, 1,0, 1,0, 0, 2'b00));
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        step(mk("fairness", 0, 1,0, 1,0, 1, (k % 2 == 0) ? 2'b01 : 2'b10));
    // Both drop: port 0 got the grant on the last handover and holds it.
    step(mk("fair_hold", 0, 0,0, 0,0, 0, 2'b01));

    // Reset mid-burst after 2 beats, stray valid ignored, fresh burst needs 4 beats.
    for (int i = 0; i < 2; i++) step(mk("mid_beat", 0, 1,0, 0,0, 1, 2'b01));
    step(mk("mid_rst",   1, 1,0, 0,0, 0, 2'b01));
    step(mk("mid_stray", 0, 0,0, 0,0, 1, 2'b00));
    step(mk("mid_req",   0, 1,0, 0,0, 0, 2'b00));
    for (int i = 0; i < 4; i++) step(mk("mid_fill", 0, 1,0, 0,0, 1, 2'b01));
    step(mk("mid_release", 0, 0,0, 0,0, 0, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
